// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan datapath: state encoding,
// digit width and the all-dark digit-enable pattern.
package seg7_pkg;

    localparam int DW       = 4;
    localparam int MAX_NDIG = 32;

    // Digit enables are active-low; slice this down to NDIG bits at the use site.
    localparam logic [MAX_NDIG-1:0] AN_OFF = '1;

    typedef enum logic {
        ST_SHOW = 1'b0,
        ST_GAP  = 1'b1
    } scan_state_t;

    function automatic int cnt_width(input int dwell, input int gap);
        int m;
        m = (dwell > gap) ? dwell : gap;
        if (m < 2) m = 2;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Scan-controller signal bundle: digit codes and pacing in, decoder code and
// digit enables out.
interface seg7_scan_ctrl_if import seg7_pkg::*; #(
    parameter int NDIG = 4
) ();

    localparam int IW = $clog2(NDIG);

    logic                 tick;
    logic                 en;
    logic [DW*NDIG-1:0]   digits_in;
    logic [NDIG-1:0]      blank;
    logic [DW-1:0]        bin;
    logic [NDIG-1:0]      an;
    logic [IW-1:0]        idx;
    logic                 frame_done;

    modport master (
        output tick, en, digits_in, blank,
        input  bin, an, idx, frame_done
    );

    modport slave (
        input  tick, en, digits_in, blank,
        output bin, an, idx, frame_done
    );

endinterface

// File: rtl/scan_lzs_mask.sv
// Leading-zero mask: bit i is set when digit i and every digit above it are
// zero. Digit 0 is never masked, so its code is not needed here.
module scan_lzs_mask import seg7_pkg::*; #(
    parameter int NDIG = 4,
    parameter int LZS  = 0
) (
    input  logic [DW*NDIG-1:DW] snap_hi,
    output logic [NDIG-1:0]     lz
);

    logic zero_above;

    always_comb begin
        lz         = '0;
        zero_above = 1'b1;
        // Walk from the most significant digit down, carrying "all zero so far".
        for (int i = NDIG - 1; i >= 1; i--) begin
            zero_above = zero_above & (snap_hi[DW*i +: DW] == '0);
            lz[i]      = zero_above & (LZS != 0);
        end
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed digit scanner: one shared decoder, NDIG active-low enables,
// tick-paced dwell per digit with an optional all-dark gap between slots.
module seg7_scan_ctrl import seg7_pkg::*; #(
    parameter int NDIG  = 4,
    parameter int DWELL = 4,
    parameter int GAP   = 1,
    parameter int LZS   = 0
) (
    input  logic             clk,
    input  logic             rst,
    seg7_scan_ctrl_if.slave  sc
);

    localparam int IW = $clog2(NDIG);
    localparam int CW = cnt_width(DWELL, GAP);

    localparam logic [CW-1:0]   DWELL_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0]   GAP_LAST   = CW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [IW-1:0]   IDX_LAST   = IW'(NDIG - 1);
    localparam logic [NDIG-1:0] AN_ALL_OFF = AN_OFF[NDIG-1:0];

    scan_state_t                  state_q, state_d;
    logic [CW-1:0]                cnt_q, cnt_d;
    logic [IW-1:0]                idx_q, idx_d;
    logic [NDIG-1:0][DW-1:0]      snap_q, snap_d;
    logic                         load_q;
    logic [NDIG-1:0]              an_q, an_d;
    logic [DW-1:0]                bin_q, bin_d;
    logic                         fd_q, fd_d;

    logic                         adv;
    logic                         step_idx;
    logic                         wrap;
    logic [NDIG-1:0][DW-1:0]      disp;
    logic [NDIG-1:0]              lz;

    // The first cycle after reset shows the digits being captured, so the
    // opening slot is not wasted on the cleared snapshot.
    assign disp = load_q ? sc.digits_in : snap_q;

    scan_lzs_mask #(
        .NDIG (NDIG),
        .LZS  (LZS)
    ) u_lzs (
        .snap_hi (disp[NDIG-1:1]),
        .lz      (lz)
    );

    always_comb begin
        // NOTE: every signal written here gets a default first, so no branch can infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        snap_d   = snap_q;
        an_d     = AN_ALL_OFF;
        bin_d    = bin_q;
        fd_d     = 1'b0;
        step_idx = 1'b0;
        wrap     = 1'b0;
        adv      = sc.en & sc.tick;

        case (state_q)
            ST_SHOW: begin
                if (adv) begin
                    if (cnt_q == DWELL_LAST) begin
                        cnt_d = '0;
                        if (GAP == 0) step_idx = 1'b1;
                        else          state_d  = ST_GAP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (adv) begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_d    = '0;
                        state_d  = ST_SHOW;
                        step_idx = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
        endcase

        if (step_idx) begin
            if (idx_q == IDX_LAST) begin
                idx_d = '0;
                wrap  = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end

        // New codes are taken only at frame boundaries so a frame never tears.
        if (wrap || load_q) snap_d = sc.digits_in;
        fd_d = wrap;

        // Outputs describe the state as it stood before this update.
        if (sc.en && state_q == ST_SHOW) begin
            bin_d = disp[idx_q];
            if (!(sc.blank[idx_q] || lz[idx_q])) an_d[idx_q] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q <= ST_SHOW;
            cnt_q   <= '0;
            idx_q   <= '0;
            // NOTE: the snapshot bank is reset so the display is defined before the first capture.
            snap_q  <= '0;
            load_q  <= 1'b1;
            an_q    <= AN_ALL_OFF;
            bin_q   <= '0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            load_q  <= 1'b0;
            an_q    <= an_d;
            bin_q   <= bin_d;
            fd_q    <= fd_d;
        end
    end

    assign sc.an         = an_q;
    assign sc.bin        = bin_q;
    assign sc.idx        = idx_q;
    assign sc.frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: three builds (plain, leading-zero, no-gap) share
// one stimulus stream and are compared each cycle against a tick-count model.
module tb_seg7_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic        en;
    logic [15:0] digits;
    logic [3:0]  blank;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    always #5 clk = ~clk;

    seg7_scan_ctrl_if #(.NDIG(4)) if_a ();
    seg7_scan_ctrl_if #(.NDIG(4)) if_l ();
    seg7_scan_ctrl_if #(.NDIG(4)) if_g ();

    assign if_a.tick = tick;   assign if_a.en = en;
    assign if_a.digits_in = digits;   assign if_a.blank = blank;
    assign if_l.tick = tick;   assign if_l.en = en;
    assign if_l.digits_in = digits;   assign if_l.blank = blank;
    assign if_g.tick = tick;   assign if_g.en = en;
    assign if_g.digits_in = digits;   assign if_g.blank = blank;

    seg7_scan_ctrl #(.NDIG(4), .DWELL(2), .GAP(1), .LZS(0)) dut_a (.clk(clk), .rst(rst), .sc(if_a.slave));
    seg7_scan_ctrl #(.NDIG(4), .DWELL(2), .GAP(1), .LZS(1)) dut_l (.clk(clk), .rst(rst), .sc(if_l.slave));
    seg7_scan_ctrl #(.NDIG(4), .DWELL(2), .GAP(0), .LZS(0)) dut_g (.clk(clk), .rst(rst), .sc(if_g.slave));

    typedef struct {
        logic [3:0] an;
        logic [3:0] bin;
        logic [1:0] idx;
        logic       fd;
    } exp_t;

    typedef struct {
        int   k;
        exp_t e;
    } sb_t;

    typedef struct {
        logic [15:0] digits;
        logic [3:0]  an;
        logic [3:0]  bin;
        logic [1:0]  idx;
        logic        fd;
    } vec_t;

    sb_t   sb_q[$];
    vec_t  tbl[13];
    string nm[3]    = '{"a", "l", "g"};
    int    dw_m[3]  = '{2, 2, 2};
    int    gp_m[3]  = '{1, 1, 0};
    int    lzs_m[3] = '{0, 1, 0};

    int          t_m[3];
    logic [15:0] snap_m[3];
    logic [3:0]  bin_m[3];
    logic        first_m[3];

    logic [3:0] lit_a, lit_l;
    int         dark_g;
    logic       hi_seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        assert_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic lz_of(input logic [15:0] d, input int s, input int lzs);
        if (lzs == 0 || s == 0) return 1'b0;
        for (int j = s; j < 4; j++)
            if (d[j*4 +: 4] != 4'h0) return 1'b0;
        return 1'b1;
    endfunction

    // Model: position in the frame follows from the number of ticks consumed.
    task automatic predict(input int k, output exp_t e);
        int len, per, pos, slot;
        logic [15:0] disp;
        len  = dw_m[k] + gp_m[k];
        per  = 4 * len;
        e.an = 4'hF;
        e.fd = 1'b0;
        if (rst) begin
            t_m[k]     = 0;
            snap_m[k]  = '0;
            bin_m[k]   = '0;
            first_m[k] = 1'b1;
            e.bin      = '0;
            e.idx      = '0;
            return;
        end
        disp  = first_m[k] ? digits : snap_m[k];
        pos   = t_m[k] % per;
        slot  = pos / len;
        e.bin = bin_m[k];
        if (en && (pos % len) < dw_m[k]) begin
            e.bin = disp[slot*4 +: 4];
            if (!blank[slot] && !lz_of(disp, slot, lzs_m[k])) e.an[slot] = 1'b0;
        end
        bin_m[k] = e.bin;
        if (first_m[k]) snap_m[k] = digits;
        if (en && tick) begin
            t_m[k]++;
            if (t_m[k] % per == 0) begin
                e.fd      = 1'b1;
                snap_m[k] = digits;
            end
        end
        first_m[k] = 1'b0;
        e.idx = 2'((t_m[k] % per) / len);
    endtask

    function automatic exp_t actual(input int k);
        exp_t a;
        case (k)
            0:       begin a.an = if_a.an; a.bin = if_a.bin; a.idx = if_a.idx; a.fd = if_a.frame_done; end
            1:       begin a.an = if_l.an; a.bin = if_l.bin; a.idx = if_l.idx; a.fd = if_l.frame_done; end
            default: begin a.an = if_g.an; a.bin = if_g.bin; a.idx = if_g.idx; a.fd = if_g.frame_done; end
        endcase
        return a;
    endfunction

    // One clock: push predictions, clock, then pop and compare mid-cycle.
    task automatic cycle();
        exp_t e, a;
        sb_t  s;
        for (int k = 0; k < 3; k++) begin
            predict(k, e);
            s.k = k;
            s.e = e;
            sb_q.push_back(s);
        end
        @(posedge clk);
        @(negedge clk);
        while (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            a = actual(s.k);
            check($sformatf("%s.an",  nm[s.k]), 32'(a.an),  32'(s.e.an));
            check($sformatf("%s.bin", nm[s.k]), 32'(a.bin), 32'(s.e.bin));
            check($sformatf("%s.idx", nm[s.k]), 32'(a.idx), 32'(s.e.idx));
            check($sformatf("%s.fd",  nm[s.k]), 32'(a.fd),  32'(s.e.fd));
        end
        lit_a = lit_a | ~if_a.an;
        lit_l = lit_l | ~if_l.an;
        if (if_g.an == 4'hF) dark_g++;
        if (if_a.bin >= 4'hA) hi_seen = 1'b1;
    endtask

    task automatic wait_fd(output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!if_a.frame_done && n < 40);
        check("fd_seen", 32'(if_a.frame_done), 32'd1);
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < 13; i++) begin
            digits = tbl[i].digits;
            cycle();
            check($sformatf("%s.an[%0d]",  tag, i), 32'(if_a.an),         32'(tbl[i].an));
            check($sformatf("%s.bin[%0d]", tag, i), 32'(if_a.bin),        32'(tbl[i].bin));
            check($sformatf("%s.idx[%0d]", tag, i), 32'(if_a.idx),        32'(tbl[i].idx));
            check($sformatf("%s.fd[%0d]",  tag, i), 32'(if_a.frame_done), 32'(tbl[i].fd));
        end
    endtask

    initial begin
        int n;
        logic [1:0] idx_hold;

        // Release with 16'h1234, DWELL=2, GAP=1, tick every cycle.
        tbl[0]  = '{16'h1234, 4'hE, 4'h4, 2'd0, 1'b0};
        tbl[1]  = '{16'h1234, 4'hE, 4'h4, 2'd0, 1'b0};
        tbl[2]  = '{16'h1234, 4'hF, 4'h4, 2'd1, 1'b0};
        tbl[3]  = '{16'h1234, 4'hD, 4'h3, 2'd1, 1'b0};
        tbl[4]  = '{16'h1234, 4'hD, 4'h3, 2'd1, 1'b0};
        tbl[5]  = '{16'h1234, 4'hF, 4'h3, 2'd2, 1'b0};
        tbl[6]  = '{16'h1234, 4'hB, 4'h2, 2'd2, 1'b0};
        tbl[7]  = '{16'h1234, 4'hB, 4'h2, 2'd2, 1'b0};
        tbl[8]  = '{16'h1234, 4'hF, 4'h2, 2'd3, 1'b0};
        tbl[9]  = '{16'h1234, 4'h7, 4'h1, 2'd3, 1'b0};
        tbl[10] = '{16'h1234, 4'h7, 4'h1, 2'd3, 1'b0};
        tbl[11] = '{16'h1234, 4'hF, 4'h1, 2'd0, 1'b1};
        tbl[12] = '{16'h1234, 4'hE, 4'h4, 2'd0, 1'b0};

        lit_a = '0; lit_l = '0; dark_g = 0; hi_seen = 1'b0;
        rst = 1'b1; tick = 1'b1; en = 1'b1; digits = 16'h0; blank = 4'h0;

        repeat (3) begin
            cycle();
            check("rst.an",  32'(if_a.an),  32'hF);
            check("rst.bin", 32'(if_a.bin), 32'h0);
        end
        rst = 1'b0;
        run_table("t1");

        // Frame period and snapshot isolation.
        wait_fd(n);
        wait_fd(n);
        check("t2.period", n, 12);
        repeat (5) cycle();
        digits  = 16'hABCD;
        hi_seen = 1'b0;
        wait_fd(n);
        check("t2.period_rest", n, 7);
        check("t2.no_tear", 32'(hi_seen), 32'd0);
        repeat (12) cycle();
        check("t2.new_frame", 32'(hi_seen), 32'd1);

        // Leading-zero suppression.
        digits = 16'h0050;
        wait_fd(n);
        lit_l = '0; lit_a = '0;
        repeat (12) cycle();
        check("t3.lit_0050", 32'(lit_l), 32'h3);
        check("t3.plain_all", 32'(lit_a), 32'hF);
        digits = 16'h0000;
        wait_fd(n);
        lit_l = '0;
        repeat (12) cycle();
        check("t3.lit_0000", 32'(lit_l), 32'h1);

        // Live blanking keeps the slot timing.
        digits = 16'h1234;
        blank  = 4'b0100;
        wait_fd(n);
        lit_a = '0;
        wait_fd(n);
        check("t4.period", n, 12);
        check("t4.lit", 32'(lit_a), 32'hB);
        blank = 4'h0;

        // Tick every third cycle, with an enable pause part-way through.
        for (int c = 0; c < 31; c++) begin
            tick = (c % 3 == 0);
            cycle();
        end
        idx_hold = if_a.idx;
        en = 1'b0;
        for (int c = 31; c < 36; c++) begin
            tick = (c % 3 == 0);
            cycle();
            check("t5.pause_an", 32'(if_a.an), 32'hF);
        end
        check("t5.pause_idx", 32'(if_a.idx), 32'(idx_hold));
        en = 1'b1;
        for (int c = 36; c < 90; c++) begin
            tick = (c % 3 == 0);
            cycle();
        end
        tick = 1'b1;

        // No-gap build never goes dark; then reset in the middle of a gap.
        wait_fd(n);
        dark_g = 0;
        repeat (16) cycle();
        check("t6.no_dark", dark_g, 0);
        wait_fd(n);
        repeat (5) cycle();
        rst = 1'b1;
        cycle();
        check("t6.rst_an",  32'(if_a.an),  32'hF);
        check("t6.rst_idx", 32'(if_a.idx), 32'h0);
        rst = 1'b0;
        run_table("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
